// File: rtl/ef_adc8_sar_ctrl.sv
// Successive-approximation controller for the EF 8-bit SAR ADC macro.
// Samples on a fabric START edge, then runs WIDTH comparator trials MSB first.
module ef_adc8_sar_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             UserCLK,
  input  logic             RST_N,
  input  logic             ENABLE,
  input  logic             START,
  input  logic             CMP,
  output logic             EN_ANA,
  output logic             SAMPLE,
  output logic [WIDTH-1:0] SAR_BITS,
  output logic [WIDTH-1:0] DATA,
  output logic             VALID,
  output logic             BUSY,
  output logic             OVERRUN
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONVERT
  } state_t;

  state_t             state, state_nxt;
  logic               start_q;
  logic               start_edge;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   bit_idx, bit_idx_nxt;
  logic               sample_nxt, valid_nxt, busy_nxt, overrun_nxt;
  logic [WIDTH-1:0]   sar_nxt, data_nxt, kept_code;

  assign start_edge = START & ~start_q;

  // Trial bit survives only if the comparator says Vin is at or above the trial level.
  assign kept_code = CMP ? SAR_BITS : (SAR_BITS & ~(WIDTH'(1) << bit_idx));

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    sample_nxt  = SAMPLE;
    sar_nxt     = SAR_BITS;
    data_nxt    = DATA;
    valid_nxt   = 1'b0;
    busy_nxt    = BUSY;
    overrun_nxt = OVERRUN;

    if (!ENABLE) begin
      state_nxt  = ST_IDLE;
      cnt_nxt    = '0;
      sample_nxt = 1'b0;
      sar_nxt    = '0;
      busy_nxt   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          sample_nxt = 1'b0;
          sar_nxt    = '0;
          busy_nxt   = 1'b0;
          if (start_edge) begin
            state_nxt   = ST_SAMPLE;
            cnt_nxt     = '0;
            sample_nxt  = 1'b1;
            busy_nxt    = 1'b1;
            overrun_nxt = 1'b0;
          end
        end

        ST_SAMPLE: begin
          if (start_edge) overrun_nxt = 1'b1;
          if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
            state_nxt   = ST_CONVERT;
            cnt_nxt     = '0;
            sample_nxt  = 1'b0;
            sar_nxt     = {1'b1, {(WIDTH-1){1'b0}}};
            bit_idx_nxt = IDX_W'(WIDTH - 1);
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end

        ST_CONVERT: begin
          if (start_edge) overrun_nxt = 1'b1;
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt_nxt = '0;
            if (bit_idx != '0) begin
              sar_nxt     = kept_code | (WIDTH'(1) << (bit_idx - IDX_W'(1)));
              bit_idx_nxt = bit_idx - IDX_W'(1);
            end else begin
              state_nxt = ST_IDLE;
              data_nxt  = kept_code;
              valid_nxt = 1'b1;
              busy_nxt  = 1'b0;
              sar_nxt   = '0;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end

        default: begin
          state_nxt  = ST_IDLE;
          sample_nxt = 1'b0;
          sar_nxt    = '0;
          busy_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge UserCLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      start_q  <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      EN_ANA   <= 1'b0;
      SAMPLE   <= 1'b0;
      SAR_BITS <= '0;
      DATA     <= '0;
      VALID    <= 1'b0;
      BUSY     <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      state    <= state_nxt;
      start_q  <= START;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      EN_ANA   <= ENABLE;
      SAMPLE   <= sample_nxt;
      SAR_BITS <= sar_nxt;
      DATA     <= data_nxt;
      VALID    <= valid_nxt;
      BUSY     <= busy_nxt;
      OVERRUN  <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_ef_adc8_sar_ctrl.sv
// Directed self-checking bench for ef_adc8_sar_ctrl with an ideal comparator model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ef_adc8_sar_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       cmp;
  logic [7:0] vin = 8'h00;
  logic       en_ana, sample, valid, busy, overrun;
  logic [7:0] sar_bits, data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Ideal comparator: high when the input is at or above the trial code.
  assign cmp = (vin >= sar_bits);

  ef_adc8_sar_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
    .UserCLK (clk),
    .RST_N   (rst_n),
    .ENABLE  (enable),
    .START   (start),
    .CMP     (cmp),
    .EN_ANA  (en_ana),
    .SAMPLE  (sample),
    .SAR_BITS(sar_bits),
    .DATA    (data),
    .VALID   (valid),
    .BUSY    (busy),
    .OVERRUN (overrun)
  );

  task automatic test_reset();
    enable = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({en_ana, sample, sar_bits, data, valid, busy, overrun} !== 20'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h exp=%h",
               {en_ana, sample, sar_bits, data, valid, busy, overrun}, 20'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({en_ana, busy} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL reset_release got=%b exp=%b", {en_ana, busy}, 2'b10);
    end
  endtask

  task automatic test_main();
    logic [7:0]  trials [8];
    logic [10:0] exp_v;
    int          busy_cycles = 0;
    int          valid_count = 0;
    trials = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    vin = 8'hA5;
    @(negedge clk);
    start = 1'b1;
    for (int e = 0; e <= 21; e++) begin
      @(negedge clk);
      if (e == 0) start = 1'b0;
      exp_v = {(e <= 3), (e <= 19), (e == 20),
               ((e >= 4 && e <= 19) ? trials[(e - 4) / 2] : 8'h00)};
      checks++;
      if ({sample, busy, valid, sar_bits} !== exp_v) begin
        failures++;
        $display("[TB] FAIL main_cycle e=%0d got=%h exp=%h", e, {sample, busy, valid, sar_bits}, exp_v);
      end
      if (busy) busy_cycles++;
      if (valid) begin
        valid_count++;
        checks++;
        if (data !== 8'hA5) begin
          failures++;
          $display("[TB] FAIL main_data got=%h exp=%h", data, 8'hA5);
        end
      end
    end
    checks++;
    if (busy_cycles != 20) begin
      failures++;
      $display("[TB] FAIL main_busy_len got=%0d exp=%0d", busy_cycles, 20);
    end
    checks++;
    if (valid_count != 1) begin
      failures++;
      $display("[TB] FAIL main_valid_count got=%0d exp=%0d", valid_count, 1);
    end
  endtask

  task automatic test_overrun();
    bit got;
    vin = 8'hA5;
    @(negedge clk);
    start = 1'b1;
    for (int e = 0; e <= 21; e++) begin
      @(negedge clk);
      if (e == 0) start = 1'b0;
      if (e == 4) start = 1'b1;
      if (e == 5) start = 1'b0;
      checks++;
      if ({busy, valid, overrun} !== {(e <= 19), (e == 20), (e >= 5)}) begin
        failures++;
        $display("[TB] FAIL overrun_cycle e=%0d got=%b exp=%b", e, {busy, valid, overrun},
                 {(e <= 19), (e == 20), (e >= 5)});
      end
      if (e == 20) begin
        checks++;
        if (data !== 8'hA5) begin
          failures++;
          $display("[TB] FAIL overrun_data got=%h exp=%h", data, 8'hA5);
        end
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, overrun} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL overrun_clear got=%b exp=%b", {busy, overrun}, 2'b10);
    end
    got = 1'b0;
    for (int e = 0; e < 30 && !got; e++) begin
      @(negedge clk);
      if (valid) got = 1'b1;
    end
    checks++;
    if (!got || data !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL overrun_rerun got_valid=%b data=%h exp=%h", got, data, 8'hA5);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] vins [3];
    bit         got;
    int         lat;
    vins = '{8'h00, 8'hFF, 8'h80};
    for (int n = 0; n < 3; n++) begin
      vin = vins[n];
      @(negedge clk);
      start = 1'b1;
      got = 1'b0;
      lat = -1;
      for (int e = 0; e < 40 && !got; e++) begin
        @(negedge clk);
        if (e == 0) start = 1'b0;
        if (valid) begin
          got = 1'b1;
          lat = e;
        end
      end
      checks++;
      if (lat != 20) begin
        failures++;
        $display("[TB] FAIL bound_latency vin=%h got=%0d exp=%0d", vins[n], lat, 20);
      end
      checks++;
      if (data !== vins[n]) begin
        failures++;
        $display("[TB] FAIL bound_data got=%h exp=%h", data, vins[n]);
      end
    end
  endtask

  task automatic test_enable_drop();
    vin = 8'hA5;
    @(negedge clk);
    start = 1'b1;
    for (int e = 0; e <= 25; e++) begin
      @(negedge clk);
      if (e == 0) start = 1'b0;
      if (e == 10) begin
        checks++;
        if ({busy, en_ana} !== 2'b11) begin
          failures++;
          $display("[TB] FAIL enable_pre got=%b exp=%b", {busy, en_ana}, 2'b11);
        end
        enable = 1'b0;
      end
      if (e == 14) start = 1'b1;
      if (e == 15) start = 1'b0;
      if (e == 11) begin
        checks++;
        if ({en_ana, sample, busy, sar_bits} !== 11'h0) begin
          failures++;
          $display("[TB] FAIL enable_drop got=%h exp=%h", {en_ana, sample, busy, sar_bits}, 11'h0);
        end
      end
      if (e >= 11) begin
        checks++;
        if ({valid, busy, overrun, data} !== {3'b000, 8'h80}) begin
          failures++;
          $display("[TB] FAIL enable_hold e=%0d got=%h exp=%h", e, {valid, busy, overrun, data},
                   {3'b000, 8'h80});
        end
      end
    end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if ({en_ana, busy} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL enable_restore got=%b exp=%b", {en_ana, busy}, 2'b10);
    end
  endtask

  task automatic test_back_to_back();
    vin = 8'hA5;
    @(negedge clk);
    start = 1'b1;
    for (int e = 0; e <= 42; e++) begin
      @(negedge clk);
      if (e == 0) start = 1'b0;
      if (e == 20) begin
        checks++;
        if ({valid, busy, data} !== {2'b10, 8'hA5}) begin
          failures++;
          $display("[TB] FAIL b2b_first got=%h exp=%h", {valid, busy, data}, {2'b10, 8'hA5});
        end
        start = 1'b1;
        vin = 8'h3C;
      end
      if (e == 21) begin
        start = 1'b0;
        checks++;
        if ({valid, busy, sample} !== 3'b011) begin
          failures++;
          $display("[TB] FAIL b2b_accept got=%b exp=%b", {valid, busy, sample}, 3'b011);
        end
      end
      if (e == 40) begin
        checks++;
        if ({valid, busy} !== 2'b01) begin
          failures++;
          $display("[TB] FAIL b2b_pre got=%b exp=%b", {valid, busy}, 2'b01);
        end
      end
      if (e == 41) begin
        checks++;
        if ({valid, busy, data} !== {2'b10, 8'h3C}) begin
          failures++;
          $display("[TB] FAIL b2b_second got=%h exp=%h", {valid, busy, data}, {2'b10, 8'h3C});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    vin = 8'hA5;
    @(negedge clk);
    start = 1'b1;
    for (int e = 0; e <= 11; e++) begin
      @(negedge clk);
      if (e == 0) start = 1'b0;
    end
    @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_pre got=%b exp=%b", busy, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({en_ana, sample, sar_bits, data, valid, busy, overrun} !== 20'h0) begin
      failures++;
      $display("[TB] FAIL rstmid_async got=%h exp=%h",
               {en_ana, sample, sar_bits, data, valid, busy, overrun}, 20'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vin = 8'h5A;
    start = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      @(negedge clk);
      if (e == 0) start = 1'b0;
      if (e == 20) begin
        checks++;
        if ({valid, data} !== {1'b1, 8'h5A}) begin
          failures++;
          $display("[TB] FAIL rstmid_fresh got=%h exp=%h", {valid, data}, {1'b1, 8'h5A});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_main();
    test_overrun();
    test_boundaries();
    test_enable_drop();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
